// File: rtl/nco_iq_pipe.sv
// Pipelined NCO: phase accumulator, quadrant fold, NSTG-stage CORDIC rotation,
// then quadrant mapping, optional negation and symmetric saturation.
module nco_iq_pipe #(
  parameter int PW   = 20,
  parameter int OW   = 12,
  parameter int NSTG = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 En,
  input  logic                 Load,
  input  logic [PW-1:0]        FCW,
  input  logic [PW-1:0]        POFS,
  input  logic                 selSign,
  input  logic                 Rdy,
  output logic                 Vld,
  output logic signed [OW-1:0] outX,
  output logic signed [OW-1:0] outY
);

  localparam int DW    = OW + 2;
  localparam int ZW    = PW;
  localparam int AMAXI = 2**(OW-1) - 1;
  localparam logic signed [DW-1:0] AMAX = DW'(AMAXI);
  localparam longint X0L = (longint'(AMAXI) * longint'(607253)) / longint'(1000000);
  localparam logic signed [DW-1:0] X0 = DW'(X0L);

  // 2*pi in Q8 for the residual-angle correction at the output stage
  localparam int TPF = 8;
  localparam logic signed [11:0] TWO_PI = 12'sd1608;
  localparam int ZRW = ZW + 12;
  localparam int PRW = DW + ZRW;
  localparam int SH  = PW + TPF;
  localparam logic signed [PRW-1:0] HALF = PRW'(1) <<< (SH - 1);

  function automatic int atanConst(input int i);
    real a;
    case (i)
      0:       a = 0.7853981633974483;
      1:       a = 0.4636476090008061;
      2:       a = 0.24497866312686414;
      3:       a = 0.12435499454676144;
      4:       a = 0.06241880999595735;
      5:       a = 0.031239833430268277;
      6:       a = 0.015623728620476831;
      7:       a = 0.007812341060101111;
      8:       a = 0.0039062301319669718;
      9:       a = 0.0019531225164788188;
      10:      a = 0.0009765621895593195;
      11:      a = 0.0004882812111948983;
      default: a = 1.0 / (2.0 ** i);
    endcase
    return int'(a * (2.0 ** PW) / 6.283185307179586);
  endfunction

  // Round-half-up arithmetic shift keeps stage truncation error unbiased
  function automatic logic signed [DW-1:0] rshift(input logic signed [DW-1:0] v, input int s);
    logic signed [DW-1:0] r;
    r = (s == 0) ? '0 : (DW'(1) <<< (s - 1));
    return (v + r) >>> s;
  endfunction

  function automatic logic signed [OW-1:0] sat(input logic signed [DW-1:0] v);
    if (v > AMAX)       return OW'(AMAX);
    else if (v < -AMAX) return OW'(-AMAX);
    else                return OW'(v);
  endfunction

  logic adv;
  assign adv = ~Vld | Rdy;

  logic [PW-1:0]        acc, fcwR, pofsR, phase;
  logic signed [ZW-1:0] pz;
  logic [1:0]           pq;
  logic                 pv;

  assign phase = acc + pofsR;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      fcwR  <= '0;
      pofsR <= '0;
      pz    <= '0;
      pq    <= '0;
      pv    <= 1'b0;
    end else if (adv) begin
      pv <= 1'b0;
      if (Load) begin
        fcwR  <= FCW;
        pofsR <= POFS;
        acc   <= '0;
      end else if (En) begin
        pz  <= {2'b00, phase[PW-3:0]};
        pq  <= phase[PW-1:PW-2];
        pv  <= 1'b1;
        acc <= acc + fcwR;
      end
    end
  end

  for (genvar i = 0; i < NSTG; i++) begin : gStage
    localparam logic signed [ZW-1:0] ATAN = ZW'(atanConst(i));
    logic signed [DW-1:0] x, y, xIn, yIn, xSh, ySh;
    logic signed [ZW-1:0] z, zIn;
    logic [1:0]           q, qIn;
    logic                 v, vIn;

    if (i == 0) begin : gFirst
      assign xIn = X0;
      assign yIn = '0;
      assign zIn = pz;
      assign qIn = pq;
      assign vIn = pv;
    end else begin : gNext
      assign xIn = gStage[i-1].x;
      assign yIn = gStage[i-1].y;
      assign zIn = gStage[i-1].z;
      assign qIn = gStage[i-1].q;
      assign vIn = gStage[i-1].v;
    end

    assign xSh = rshift(xIn, i);
    assign ySh = rshift(yIn, i);

    always_ff @(posedge clk) begin
      if (rst) begin
        x <= '0;
        y <= '0;
        z <= '0;
        q <= '0;
        v <= 1'b0;
      end else if (adv) begin
        if (!zIn[ZW-1]) begin
          x <= xIn - ySh;
          y <= yIn + xSh;
          z <= zIn - ATAN;
        end else begin
          x <= xIn + ySh;
          y <= yIn - xSh;
          z <= zIn + ATAN;
        end
        q <= qIn;
        v <= vIn;
      end
    end
  end

  logic signed [DW-1:0]  lx, ly, xc, yc, mx, my;
  logic signed [ZW-1:0]  lz;
  logic [1:0]            lq;
  logic                  lv;
  logic signed [ZRW-1:0] zRad;
  logic signed [PRW-1:0] xzp, yzp;

  assign lx = gStage[NSTG-1].x;
  assign ly = gStage[NSTG-1].y;
  assign lz = gStage[NSTG-1].z;
  assign lq = gStage[NSTG-1].q;
  assign lv = gStage[NSTG-1].v;

  // Leftover CORDIC angle is applied as a first-order small-angle rotation
  always_comb begin
    zRad = ZRW'(lz) * ZRW'(TWO_PI);
    xzp  = PRW'(lx) * PRW'(zRad);
    yzp  = PRW'(ly) * PRW'(zRad);
    xc   = lx - DW'((yzp + HALF) >>> SH);
    yc   = ly + DW'((xzp + HALF) >>> SH);
    mx   = xc;
    my   = yc;
    case (lq)
      2'd0: begin mx = xc;  my = yc;  end
      2'd1: begin mx = -yc; my = xc;  end
      2'd2: begin mx = -xc; my = -yc; end
      2'd3: begin mx = yc;  my = -xc; end
      default: ;
    endcase
    if (selSign) begin
      mx = -mx;
      my = -my;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Vld  <= 1'b0;
      outX <= '0;
      outY <= '0;
    end else if (adv) begin
      Vld <= lv;
      if (lv) begin
        outX <= sat(mx);
        outY <= sat(my);
      end
    end
  end

endmodule

// File: doc/nco_iq_pipe.md
NCO_IQ_PIPE -- requirements
Module: nco_iq_pipe

Interface
REQ-001 SHALL have parameter PW, default 20: phase accumulator / angle width in bits (min 8).
REQ-002 SHALL have parameter OW, default 12: signed output sample width (min 8).
REQ-003 SHALL have parameter NSTG, default 8: CORDIC stage count (2..OW).
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port En  input  1  request one new sample this cycle.
REQ-007 SHALL have port Load  input  1  latch FCW/POFS and clear the accumulator.
REQ-008 SHALL have port FCW  input  PW  frequency control word, unsigned.
REQ-009 SHALL have port POFS  input  PW  phase offset, unsigned, 2^PW = 2π.
REQ-010 SHALL have port selSign  input  1  negate both outputs when 1.
REQ-011 SHALL have port Rdy  input  1  downstream accepts the output sample.
REQ-012 SHALL have port Vld  output  1  outX/outY hold a valid sample.
REQ-013 SHALL have port outX  output  OW  cosine, two's complement.
REQ-014 SHALL have port outY  output  OW  sine, two's complement.

Function
REQ-015 SHALL define adv = ~Vld | Rdy; when adv=0, every pipeline register, the accumulator and FCW_r/POFS_r SHALL hold, and En/Load SHALL be ignored.
REQ-016 SHALL, on adv & Load, set FCW_r<=FCW, POFS_r<=POFS and acc<=0, and issue no sample that cycle (Load beats En).
REQ-017 SHALL, on adv & En & ~Load, issue phase p = (acc + POFS_r) mod 2^PW into stage 0 with valid=1, then set acc <= (acc + FCW_r) mod 2^PW (free wrap, no flag).
REQ-018 SHALL, on adv & ~En & ~Load, insert a bubble (valid=0) and leave acc unchanged.
REQ-019 SHALL fold the phase: q = p[PW-1:PW-2]; residual r = p[PW-3:0], zero-extended to a signed angle z0 in units of 2π/2^PW.
REQ-020 SHALL start CORDIC rotation with x0 = floor((2^(OW-1)-1) * 0.607253), y0 = 0, on an internal datapath of OW+2 bits.
REQ-021 SHALL, at stage i (0..NSTG-1), use d = sign(z); x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_i, where atan_i = round(atan(2^-i) * 2^PW / 2π) comes from a generate-time constant.
REQ-022 SHALL, at the output stage, apply the quadrant mapping: q=0 (x,y); q=1 (-y,x); q=2 (-x,-y); q=3 (y,-x).
REQ-023 SHALL then negate both components if selSign=1, sample selSign on the output-stage advance, and saturate to [-(2^(OW-1)-1), 2^(OW-1)-1].
REQ-024 SHALL carry q and valid alongside each stage.
REQ-025 SHALL have latency LAT = NSTG+2 advancing cycles from issue to Vld (1 phase stage, NSTG CORDIC stages, 1 output stage).
REQ-026 SHALL keep outX/outY/Vld stable while Vld=1 & Rdy=0, and SHALL never drop or duplicate a sample.
REQ-027 SHALL drain bubbles through the pipeline: with Vld=0, stages advance regardless of Rdy.
REQ-028 SHALL meet an accuracy of |error| <= 3 LSB against ideal A·cos/sin, A = 2^(OW-1)-1, for NSTG = 8 and OW = 12.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, clear acc, FCW_r, POFS_r, all stage data/valid/q, outX=0, outY=0 and Vld=0.
REQ-030 SHALL give rst priority over Load, En and stall; a sample in flight at reset SHALL be discarded, never emitted.
REQ-031 SHALL allow the first valid sample after rst release no earlier than LAT cycles after the first accepted En.

Verification (PW=20, OW=12, NSTG=8, LAT=10)
REQ-032 Reset: rst=1 for 3 cycles mid-stream -> next cycle Vld=0, outX=outY=0; no stale sample after release.
REQ-033 DC: Load FCW=0, POFS=0, then En=1, Rdy=1 -> Vld rises 10 cycles later; outX=2047±3, outY=0±3 steady.
REQ-034 Quadrants: POFS=0x40000 / 0x80000 / 0xC0000 -> (outX,outY) ≈ (0,2047) / (-2047,0) / (0,-2047), each ±3.
REQ-035 Tone: FCW=0x10000, En=1 continuous -> period 16; sample k=2 ≈ (1447,1447); k=6 ≈ (-1447,1447).
REQ-036 Backpressure: Rdy=0 for 5 cycles while Vld=1, En=1 -> outputs frozen; after Rdy=1 the sequence resumes with no gap or repeat; interleaved En=0 bubbles are absorbed.
REQ-037 Edge cases: Load=En=1 in the same cycle -> no sample issued, acc=0. POFS=0xFFFFF, FCW=0x00002 -> wrap without glitch. selSign=1 -> both outputs exactly negated.
